qs_arbiter: RTL

//  Shares one 10-entry insertion sorter (qs) between two AXI-Stream requesters.

---
 rtl/qs_pkg.sv | 11 +
 rtl/qs_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/qs_pkg.sv
// qs_pkg: shared state encodings and defaults for the qs sorter arbiter
package qs_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;
  localparam int QS_BATCH  = 10;
  localparam int QS_DATA_W = 32;
endpackage

// File: rtl/qs_arbiter.sv
// qs_arbiter: grants one shared insertion sorter to one of two stream requesters per whole batch
module qs_arbiter
  import qs_pkg::*;
#(
  parameter int pDATA_WIDTH = QS_DATA_W,
  parameter int BATCH       = QS_BATCH,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_tvalid,
  input  logic [pDATA_WIDTH-1:0] s0_tdata,
  output logic                   s0_tready,
  input  logic                   s1_tvalid,
  input  logic [pDATA_WIDTH-1:0] s1_tdata,
  output logic                   s1_tready,
  output logic                   m0_tvalid,
  output logic [pDATA_WIDTH-1:0] m0_tdata,
  output logic                   m0_tlast,
  input  logic                   m0_tready,
  output logic                   m1_tvalid,
  output logic [pDATA_WIDTH-1:0] m1_tdata,
  output logic                   m1_tlast,
  input  logic                   m1_tready,
  output logic                   srt_ss_tvalid,
  output logic [pDATA_WIDTH-1:0] srt_ss_tdata,
  input  logic                   srt_ss_tready,
  input  logic                   srt_sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] srt_sm_tdata,
  output logic                   srt_sm_tready,
  output logic                   srt_clr,
  output logic                   grant,
  output logic                   busy,
  output logic [15:0]            batch_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH - 1);
  state_t           state, state_nxt;
  logic             rr_ptr, load, drain, in_xfer, out_xfer, last_out;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  always_comb begin
    load          = state == ST_LOAD;
    drain         = state == ST_DRAIN;
    last_out      = out_cnt == LAST;
    srt_clr       = state == ST_FLUSH;
    busy          = state != ST_IDLE;
    srt_ss_tvalid = load & (grant ? s1_tvalid : s0_tvalid);
    srt_ss_tdata  = load ? (grant ? s1_tdata : s0_tdata) : '0;
    s0_tready     = load & ~grant & srt_ss_tready;
    s1_tready     = load & grant & srt_ss_tready;
    srt_sm_tready = drain & (grant ? m1_tready : m0_tready);
    m0_tvalid     = drain & ~grant & srt_sm_tvalid;
    m1_tvalid     = drain & grant & srt_sm_tvalid;
    m0_tdata      = (drain & ~grant) ? srt_sm_tdata : '0;
    m1_tdata      = (drain & grant) ? srt_sm_tdata : '0;
    m0_tlast      = drain & ~grant & last_out;
    m1_tlast      = drain & grant & last_out;
    in_xfer       = srt_ss_tvalid & srt_ss_tready;
    out_xfer      = srt_sm_tvalid & srt_sm_tready;
    state_nxt     = state == ST_IDLE  ? ((s0_tvalid | s1_tvalid) ? ST_LOAD : ST_IDLE) :
                    state == ST_LOAD  ? ((in_xfer && in_cnt == LAST) ? ST_DRAIN : ST_LOAD) :
                    state == ST_DRAIN ? ((out_xfer && last_out) ? ST_FLUSH : ST_DRAIN) :
                                        ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= 1'b0;
      rr_ptr    <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      batch_cnt <= '0;
    end else begin
      state <= state_nxt;
      // contention resolves via rr_ptr; a lone requester wins outright
      if (state == ST_IDLE && (s0_tvalid | s1_tvalid))
        grant <= (s0_tvalid & s1_tvalid) ? rr_ptr : s1_tvalid;
      if (in_xfer) in_cnt <= in_cnt + 1'b1;
      if (out_xfer) out_cnt <= out_cnt + 1'b1;
      if (srt_clr) begin
        rr_ptr    <= ~grant;
        batch_cnt <= batch_cnt + 1'b1;
        in_cnt    <= '0;
        out_cnt   <= '0;
      end
    end
endmodule
